// File: rtl/vm_keypad_pkg.sv
// Shared types and constants for the vending-machine 4x4 keypad scanner.
// Holds the FSM state encoding, the keypad geometry and the row-drive helpers.
package vm_keypad_pkg;

    localparam int unsigned NUM_ROWS   = 4;
    localparam int unsigned NUM_COLS   = 4;
    localparam int unsigned KEY_CODE_W = 4;
    localparam int unsigned ROW_IDX_W  = 2;
    localparam int unsigned COL_IDX_W  = 2;
    localparam int unsigned CNT_W      = 8;

    // Row 0 driven low out of reset
    localparam logic [NUM_ROWS-1:0] ROW_DRIVE_RST = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Active-low one-hot row drive for a given row index
    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_IDX_W-1:0] idx);
        return ~(NUM_ROWS'(1) << idx);
    endfunction

    // Index of the lowest-numbered column pulled low (0 if none)
    function automatic logic [COL_IDX_W-1:0] lowest_low_col(input logic [NUM_COLS-1:0] cols_n);
        logic [COL_IDX_W-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (!found && !cols_n[i]) begin
                idx   = COL_IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Two-flop synchronizer for a slow data-rate square wave followed by a
// rising-edge detector; tick is a single clk-cycle pulse per input period.
module tick_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    // Synchronize the divider output and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            meta_q     <= async_in;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign tick = sync_q & ~sync_dly_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debounce, timed by ticks derived
// from the 10 kHz divider output (sampled as data on clk_50Mhz).
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_debounce
    import vm_keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned REPEAT_TICKS   = 5000
) (
    input  logic                  clk_50Mhz,
    input  logic                  rst_n,
    input  logic                  clk_10khz,
    input  logic [NUM_COLS-1:0]   col_in,
    output logic [NUM_ROWS-1:0]   row_out,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_params
        $error("keypad_scan_debounce: DEBOUNCE_TICKS or REPEAT_TICKS out of range");
    end

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_TICKS);

    logic tick;

    tick_edge_sync u_tick_sync (
        .clk      (clk_50Mhz),
        .rst_n    (rst_n),
        .async_in (clk_10khz),
        .tick     (tick)
    );

    logic [NUM_COLS-1:0] col_meta_q;
    logic [NUM_COLS-1:0] col_sync_q;

    // Two-flop synchronizer for the asynchronous, pulled-up column lines
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    kp_state_e               state_q,    state_d;
    logic [ROW_IDX_W-1:0]    row_idx_q,  row_idx_d;
    logic [ROW_IDX_W-1:0]    cand_row_q, cand_row_d;
    logic [COL_IDX_W-1:0]    cand_col_q, cand_col_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic [KEY_CODE_W-1:0]   key_code_q, key_code_d;
    logic                    key_valid_q, key_valid_d;
    logic                    key_held_q, key_held_d;
    logic [NUM_ROWS-1:0]     row_out_q,  row_out_d;
    logic                    cand_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_W = 16;
    localparam logic [RPT_W-1:0] RPT_LIMIT = RPT_W'(REPEAT_TICKS);

    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
`endif

    // Scan/debounce FSM next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cand_low    = ~col_sync_q[cand_col_q];
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_inc     = (rpt_q == '1) ? rpt_q : rpt_q + RPT_W'(1);
`endif

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_sync_q != '1) begin
                        cand_row_d = row_idx_q;
                        cand_col_d = lowest_low_col(col_sync_q);
                        cnt_d      = CNT_W'(1);
                        if (DB_LIMIT <= CNT_W'(1)) begin
                            key_code_d  = {row_idx_q, lowest_low_col(col_sync_q)};
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rpt_d       = '0;
`endif
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + ROW_IDX_W'(1);
                    end
                end

                DEBOUNCE: begin
                    if (cand_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_LIMIT) begin
                            key_code_d  = {cand_row_q, cand_col_q};
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rpt_d       = '0;
`endif
                        end
                    end else begin
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + ROW_IDX_W'(1);
                        state_d   = SCAN;
                    end
                end

                HELD: begin
                    if (!cand_low) begin
`ifdef KEYPAD_REPEAT_EN
                        rpt_d = '0;
`endif
                        if (DB_LIMIT <= CNT_W'(1)) begin
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                            row_idx_d  = row_idx_q + ROW_IDX_W'(1);
                            state_d    = SCAN;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = RELEASE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_inc >= RPT_LIMIT) begin
                        key_valid_d = 1'b1;
                        rpt_d       = '0;
                    end else begin
                        rpt_d = rpt_inc;
                    end
`endif
                end

                RELEASE: begin
                    if (!cand_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_LIMIT) begin
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                            row_idx_d  = row_idx_q + ROW_IDX_W'(1);
                            state_d    = SCAN;
                        end
                    end else begin
                        // Release bounce: back to HELD without a new strobe
                        cnt_d   = '0;
                        state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rpt_d   = '0;
`endif
                    end
                end

                default: begin
                    state_d = SCAN;
                end
            endcase
        end

        row_out_d = row_drive(row_idx_d);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            row_idx_q   <= '0;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            row_out_q   <= ROW_DRIVE_RST;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            row_out_q   <= row_out_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
